// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared state encoding and address constants for mem_access_unit
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Byte-address LSBs that select a byte within a word
  localparam int WORD_OFS = 2;
  localparam int TIMER_W  = 16;

endpackage

// File: rtl/mem_access_unit_wait_timer.sv
// rtl/mem_access_unit_wait_timer.sv - wait-cycle counter with clear, enable and terminal count
module mem_access_unit_wait_timer
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - req/ack memory sequencer for the multicycle MIPS core, owns IR and MDR
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int N       = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic              req_ir,
  input  logic [ADDR_W-1:0] addr,
  input  logic [N-1:0]      wdata,
  input  logic              err_clr,
  output logic              req_ready,
  output logic              done,
  output logic              err_align,
  output logic              err_tmo,
  output logic [N-1:0]      ir,
  output logic [N-1:0]      mdr,
  output logic [5:0]        op_code,
  output logic [5:0]        funct,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [N-1:0]      mem_wdata,
  input  logic [N-1:0]      mem_rdata,
  input  logic              mem_ack
);

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic                r_ir_sel;
  logic                r_align;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-3:0]   r_mem_addr;
  logic [N-1:0]        r_mem_wdata;
  logic [N-1:0]        r_ir;
  logic [N-1:0]        r_mdr;
  logic                r_err_align;
  logic                r_err_tmo;
  logic                w_accept;
  logic                w_misaligned;
  logic                w_tc;
  logic                w_ack_ok;
  logic                w_tmo;

  assign w_accept     = req_valid && (r_state == ST_IDLE);
  assign w_misaligned = |addr[WORD_OFS-1:0];
  assign w_ack_ok     = (r_state == ST_ACCESS) && !r_align && mem_ack;
  assign w_tmo        = (r_state == ST_ACCESS) && !r_align && !mem_ack && w_tc;

  mem_access_unit_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state != ST_ACCESS),
    .i_en  (r_state == ST_ACCESS),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Misaligned requests still pass through ACCESS (without mem_req) so every
  // transaction has the same minimum accept-to-done latency.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_ACCESS;
      ST_ACCESS: if (r_align || mem_ack || w_tc) w_next = ST_FINISH;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == ST_IDLE);
    done      = (r_state == ST_FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_ir_sel    <= 1'b0;
      r_align     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ir        <= '0;
      r_mdr       <= '0;
      r_err_align <= 1'b0;
      r_err_tmo   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we        <= req_we;
        r_ir_sel    <= req_ir;
        r_align     <= w_misaligned;
        r_mem_req   <= !w_misaligned;
        r_mem_we    <= req_we && !w_misaligned;
        r_mem_addr  <= addr[ADDR_W-1:WORD_OFS];
        r_mem_wdata <= wdata;
      end else if (w_ack_ok || w_tmo) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
      end
      if (w_ack_ok && !r_we) begin
        if (r_ir_sel) r_ir  <= mem_rdata;
        else          r_mdr <= mem_rdata;
      end
      r_err_align <= (w_accept && w_misaligned) || (r_err_align && !err_clr);
      r_err_tmo   <= w_tmo || (r_err_tmo && !err_clr);
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign ir        = r_ir;
  assign mdr       = r_mdr;
  assign op_code   = r_ir[31:26];
  assign funct     = r_ir[5:0];
  assign err_align = r_err_align;
  assign err_tmo   = r_err_tmo;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit (TIMEOUT=4)
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic        req_ir = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        err_clr = 1'b0;
  logic        req_ready;
  logic        done;
  logic        err_align;
  logic        err_tmo;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic [5:0]  op_code;
  logic [5:0]  funct;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int vectors = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] mdr;
    logic        ea;
    logic        et;
    int          lat;
    int          nreq;
  } exp_t;

  exp_t sb[$];

  mem_access_unit #(.N(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_ir(req_ir),
    .addr(addr), .wdata(wdata), .err_clr(err_clr), .req_ready(req_ready), .done(done),
    .err_align(err_align), .err_tmo(err_tmo), .ir(ir), .mdr(mdr), .op_code(op_code),
    .funct(funct), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic xact(input logic we, input logic irs, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input int k,
                      input logic ack_en, input exp_t e);
    int   n;
    int   nreq;
    bit   got;
    exp_t p;
    sb.push_back(e);
    chk("ready_before", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_ir = irs; addr = a; wdata = wd;
    tick();
    req_valid = 1'b0; err_clr = 1'b0; addr = ~a; wdata = ~wd;
    n = 1; nreq = 0; got = 0;
    while (!got && n < 40) begin
      mem_ack = 1'b0;
      mem_rdata = 32'hBAD0_0000;
      if (done) begin
        got = 1;
        p = sb.pop_front();
        chk("latency", n, p.lat);
        chk("req_cycles", nreq, p.nreq);
        chk("ir", ir, p.ir);
        chk("mdr", mdr, p.mdr);
        chk("err_align", {31'b0, err_align}, {31'b0, p.ea});
        chk("err_tmo", {31'b0, err_tmo}, {31'b0, p.et});
        chk("mem_req_at_done", {31'b0, mem_req}, 32'd0);
      end else begin
        if (mem_req) begin
          nreq++;
          if (mem_addr !== a[31:2] || mem_we !== we || mem_wdata !== wd)
            chk("mem_bus_stable", {mem_addr, mem_we, 1'b0}, {a[31:2], we, 1'b0});
        end
        if (ack_en && n == 1 + k) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
        end
        tick();
        n++;
      end
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    mem_ack = 1'b0;
    tick();
    chk("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=stuck expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_bus", {mem_req, mem_we, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_ir_mdr", ir | mdr, 32'd0);
    chk("rst_errs", {30'b0, err_align, err_tmo}, 32'd0);
    rst = 1'b0;
    tick();

    xact(1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'h2008_0005, 0, 1'b1,
         '{32'h2008_0005, 32'h0, 1'b0, 1'b0, 2, 1});
    chk("op_code", {26'b0, op_code}, 32'h08);
    chk("funct", {26'b0, funct}, 32'h05);

    xact(1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3, 1'b1,
         '{32'h2008_0005, 32'hDEAD_BEEF, 1'b0, 1'b0, 5, 4});

    xact(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hFFFF_FFFF, 1, 1'b1,
         '{32'h2008_0005, 32'hDEAD_BEEF, 1'b0, 1'b0, 3, 2});

    xact(1'b0, 1'b1, 32'h0000_0006, 32'h0, 32'h1111_1111, 0, 1'b1,
         '{32'h2008_0005, 32'hDEAD_BEEF, 1'b1, 1'b0, 2, 0});
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_align_clr", {31'b0, err_align}, 32'd0);

    err_clr = 1'b1;
    xact(1'b1, 1'b0, 32'h0000_0043, 32'h5555_AAAA, 32'h0, 0, 1'b1,
         '{32'h2008_0005, 32'hDEAD_BEEF, 1'b1, 1'b0, 2, 0});
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    xact(1'b0, 1'b0, 32'h0000_0200, 32'h0, 32'h7777_7777, 0, 1'b0,
         '{32'h2008_0005, 32'hDEAD_BEEF, 1'b0, 1'b1, 5, 4});
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_tmo_clr", {31'b0, err_tmo}, 32'd0);

    xact(1'b0, 1'b0, 32'h0000_0204, 32'h0, 32'hCAFE_F00D, 3, 1'b1,
         '{32'h2008_0005, 32'hCAFE_F00D, 1'b0, 1'b0, 5, 4});

    req_valid = 1'b1; req_we = 1'b0; req_ir = 1'b1; addr = 32'h0000_0040;
    tick();
    req_valid = 1'b0;
    tick();
    chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_req", {31'b0, mem_req}, 32'd0);
    chk("async_rst_ir_mdr", ir | mdr, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_done_after_rst", {31'b0, done}, 32'd0);
    end
    mem_ack = 1'b0;
    chk("late_ack_ignored", ir, 32'd0);

    xact(1'b0, 1'b1, 32'h0000_0000, 32'h0, 32'h0000_0020, 2, 1'b1,
         '{32'h0000_0020, 32'h0, 1'b0, 1'b0, 4, 3});

    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
